// File: rtl/dsp_ram_arbiter.sv
// dsp_ram_arbiter: shares data RAM port A between DSP core (priority) and host (bounded wait).
// Optional zero-fill sweep engine, built only when DSP_RAM_CLEAR_EN is defined.
module dsp_ram_arbiter #(
  parameter int AW            = 11,
  parameter int DW            = 16,
  parameter int HOST_WAIT_MAX = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_ad,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [0:0] {RUN = 1'b0, CLEAR = 1'b1} state_e;

  localparam logic [3:0]    WAIT_MAX = 4'(HOST_WAIT_MAX);
  localparam logic [AW-1:0] LAST_AD  = {AW{1'b1}};
`ifdef DSP_RAM_CLEAR_EN
  localparam state_e RESET_STATE = CLEAR;
`else
  localparam state_e RESET_STATE = RUN;
`endif

  state_e        state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          core_rvalid_q, host_rvalid_q;
  logic          core_win_s, host_win_s;
  logic [AW-1:0] sweep_s;
  logic          clr_done_s;

  // Arbitration: host only overrides a requesting core once it has waited WAIT_MAX cycles.
  always_comb begin
    core_win_s = 1'b0;
    host_win_s = 1'b0;
    if (resetn && (state_q == RUN)) begin
      if (host_req && (!core_req || (wait_cnt_q == WAIT_MAX))) begin
        host_win_s = 1'b1;
      end else if (core_req) begin
        core_win_s = 1'b1;
      end else begin
        core_win_s = 1'b0;
      end
    end else begin
      host_win_s = 1'b0;
    end
  end

  // RAM port A mux: sweep, host winner, core winner, or idle.
  always_comb begin
    ram_ce  = 1'b0;
    ram_we  = 1'b0;
    ram_ad  = {AW{1'b0}};
    ram_din = {DW{1'b0}};
    if (!resetn) begin
      ram_ce = 1'b0;
    end else if (state_q == CLEAR) begin
      ram_ce = 1'b1;
      ram_we = 1'b1;
      ram_ad = sweep_s;
    end else if (host_win_s) begin
      ram_ce  = 1'b1;
      ram_we  = host_we;
      ram_ad  = host_addr;
      ram_din = host_wdata;
    end else if (core_win_s) begin
      ram_ce  = 1'b1;
      ram_we  = core_we;
      ram_ad  = core_addr;
      ram_din = core_wdata;
    end else begin
      ram_ce = 1'b0;
    end
  end

  // Next-state and host wait counter.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
`ifdef DSP_RAM_CLEAR_EN
      RUN:     state_d = clr_start ? CLEAR : RUN;
      CLEAR:   state_d = (sweep_s == LAST_AD) ? RUN : CLEAR;
`else
      RUN:     state_d = RUN;
      CLEAR:   state_d = RUN;
`endif
      default: state_d = RUN;
    endcase
    if (!host_req || host_win_s) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // State, wait counter and read-return flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= RESET_STATE;
      wait_cnt_q    <= 4'd0;
      core_rvalid_q <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      core_rvalid_q <= core_win_s && !core_we;
      host_rvalid_q <= host_win_s && !host_we;
    end
  end

`ifdef DSP_RAM_CLEAR_EN
  logic [AW-1:0] sweep_q, sweep_d;
  logic          clr_done_q, clr_done_d;

  // Sweep address advances only while clearing and rests at zero otherwise.
  always_comb begin
    sweep_d    = {AW{1'b0}};
    clr_done_d = 1'b0;
    if (state_q == CLEAR) begin
      sweep_d    = sweep_q + {{(AW-1){1'b0}}, 1'b1};
      clr_done_d = (sweep_q == LAST_AD);
    end else begin
      sweep_d = {AW{1'b0}};
    end
  end

  // Sweep counter and completion pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sweep_q    <= {AW{1'b0}};
      clr_done_q <= 1'b0;
    end else begin
      sweep_q    <= sweep_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign sweep_s    = sweep_q;
  assign clr_done_s = clr_done_q;
  assign clr_busy   = resetn && (state_q == CLEAR);
`else
  logic unused_clr_s;
  assign unused_clr_s = &{1'b0, clr_start};
  assign sweep_s      = {AW{1'b0}};
  assign clr_done_s   = 1'b0;
  assign clr_busy     = 1'b0;
`endif

  assign clr_done    = clr_done_s;
  assign core_gnt    = core_win_s;
  assign host_gnt    = host_win_s;
  assign core_rvalid = core_rvalid_q;
  assign host_rvalid = host_rvalid_q;
  assign core_rdata  = ram_dout;
  assign host_rdata  = ram_dout;

endmodule

// File: tb/tb_dsp_ram_arbiter.sv
// Directed self-checking bench for dsp_ram_arbiter with a behavioural 2Kx16 RAM on port A.
module tb_dsp_ram_arbiter;
  localparam int AW = 11;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic resetn;
  logic core_req, core_we, host_req, host_we, clr_start;
  logic [AW-1:0] core_addr, host_addr, ram_ad;
  logic [DW-1:0] core_wdata, host_wdata, core_rdata, host_rdata, ram_din, ram_dout;
  logic core_gnt, core_rvalid, host_gnt, host_rvalid, clr_busy, clr_done, ram_ce, ram_we;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dsp_ram_arbiter #(.AW(AW), .DW(DW), .HOST_WAIT_MAX(4)) dut (
    .clk(clk), .resetn(resetn),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // RAM model: filled with a non-zero pattern during reset, output registered.
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < 2**AW; k++) mem[k] <= 16'hA5A5;
    end else if (ram_ce) begin
      if (ram_we) mem[ram_ad] <= ram_din;
      else        ram_dout    <= mem[ram_ad];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic c_req; logic c_we; logic [AW-1:0] c_ad; logic [DW-1:0] c_wd;
    logic h_req; logic h_we; logic [AW-1:0] h_ad; logic [DW-1:0] h_wd;
    logic e_cg;  logic e_hg; logic e_ce; logic e_we; logic [AW-1:0] e_ad; logic [DW-1:0] e_din;
    logic e_crv; logic e_hrv; logic [DW-1:0] e_rd; logic [3:0] e_wait;
  } vec_t;

  localparam int NV = 15;
  vec_t vec [NV];

  initial begin
    // idle / core write 7FF / core read 7FF / read return
    vec[0]  = '{1'b0,1'b0,11'h000,16'h0000, 1'b0,1'b0,11'h000,16'h0000, 1'b0,1'b0,1'b0,1'b0,11'h000,16'h0000, 1'b0,1'b0,16'h0000,4'd0};
    vec[1]  = '{1'b1,1'b1,11'h7FF,16'h1234, 1'b0,1'b0,11'h000,16'h0000, 1'b1,1'b0,1'b1,1'b1,11'h7FF,16'h1234, 1'b0,1'b0,16'h0000,4'd0};
    vec[2]  = '{1'b1,1'b0,11'h7FF,16'h0000, 1'b0,1'b0,11'h000,16'h0000, 1'b1,1'b0,1'b1,1'b0,11'h7FF,16'h0000, 1'b0,1'b0,16'h0000,4'd0};
    vec[3]  = '{1'b0,1'b0,11'h000,16'h0000, 1'b0,1'b0,11'h000,16'h0000, 1'b0,1'b0,1'b0,1'b0,11'h000,16'h0000, 1'b1,1'b0,16'h1234,4'd0};
    // host alone: write BEEF to 000, read it back
    vec[4]  = '{1'b0,1'b0,11'h000,16'h0000, 1'b1,1'b1,11'h000,16'hBEEF, 1'b0,1'b1,1'b1,1'b1,11'h000,16'hBEEF, 1'b0,1'b0,16'h0000,4'd0};
    vec[5]  = '{1'b0,1'b0,11'h000,16'h0000, 1'b1,1'b0,11'h000,16'h0000, 1'b0,1'b1,1'b1,1'b0,11'h000,16'h0000, 1'b0,1'b0,16'h0000,4'd0};
    vec[6]  = '{1'b0,1'b0,11'h000,16'h0000, 1'b0,1'b0,11'h000,16'h0000, 1'b0,1'b0,1'b0,1'b0,11'h000,16'h0000, 1'b0,1'b1,16'hBEEF,4'd0};
    // both reading every cycle: core x4, host, core
    vec[7]  = '{1'b1,1'b0,11'h7FF,16'h0000, 1'b1,1'b0,11'h000,16'h0000, 1'b1,1'b0,1'b1,1'b0,11'h7FF,16'h0000, 1'b0,1'b0,16'h0000,4'd0};
    vec[8]  = '{1'b1,1'b0,11'h7FF,16'h0000, 1'b1,1'b0,11'h000,16'h0000, 1'b1,1'b0,1'b1,1'b0,11'h7FF,16'h0000, 1'b1,1'b0,16'h1234,4'd1};
    vec[9]  = '{1'b1,1'b0,11'h7FF,16'h0000, 1'b1,1'b0,11'h000,16'h0000, 1'b1,1'b0,1'b1,1'b0,11'h7FF,16'h0000, 1'b1,1'b0,16'h1234,4'd2};
    vec[10] = '{1'b1,1'b0,11'h7FF,16'h0000, 1'b1,1'b0,11'h000,16'h0000, 1'b1,1'b0,1'b1,1'b0,11'h7FF,16'h0000, 1'b1,1'b0,16'h1234,4'd3};
    vec[11] = '{1'b1,1'b0,11'h7FF,16'h0000, 1'b1,1'b0,11'h000,16'h0000, 1'b0,1'b1,1'b1,1'b0,11'h000,16'h0000, 1'b1,1'b0,16'h1234,4'd4};
    vec[12] = '{1'b1,1'b0,11'h7FF,16'h0000, 1'b1,1'b0,11'h000,16'h0000, 1'b1,1'b0,1'b1,1'b0,11'h7FF,16'h0000, 1'b0,1'b1,16'hBEEF,4'd0};
    vec[13] = '{1'b0,1'b0,11'h000,16'h0000, 1'b0,1'b0,11'h000,16'h0000, 1'b0,1'b0,1'b0,1'b0,11'h000,16'h0000, 1'b1,1'b0,16'h1234,4'd1};
    vec[14] = '{1'b0,1'b0,11'h000,16'h0000, 1'b0,1'b0,11'h000,16'h0000, 1'b0,1'b0,1'b0,1'b0,11'h000,16'h0000, 1'b0,1'b0,16'h0000,4'd0};

    resetn = 1'b0; clr_start = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 11'h000; core_wdata = 16'h0000;
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'h000; host_wdata = 16'h0000;
    repeat (3) @(negedge clk);
    #1;
    check("rst core_gnt", 32'(core_gnt), 32'd0);
    check("rst host_gnt", 32'(host_gnt), 32'd0);
    check("rst ram_ce", 32'(ram_ce), 32'd0);
    check("rst ram_we", 32'(ram_we), 32'd0);
    check("rst core_rvalid", 32'(core_rvalid), 32'd0);
    check("rst host_rvalid", 32'(host_rvalid), 32'd0);
    check("rst clr_done", 32'(clr_done), 32'd0);
    check("rst wait_cnt", 32'(dut.wait_cnt_q), 32'd0);
    core_req = 1'b0; host_req = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

`ifdef DSP_RAM_CLEAR_EN
    begin
      int sweep_err = 0;
      host_req = 1'b1; host_we = 1'b0; host_addr = 11'h123;
      for (int i = 0; i < 2**AW; i++) begin
        clr_start = (i == 16'h100);
        #1;
        if (!(clr_busy && ram_ce && ram_we && ram_din == 16'h0000 && ram_ad == AW'(i) &&
              !host_gnt && !core_gnt && !clr_done)) sweep_err++;
        @(negedge clk);
      end
      clr_start = 1'b0;
      #1;
      check("sweep cycles", 32'(sweep_err), 32'd0);
      check("sweep clr_done", 32'(clr_done), 32'd1);
      check("sweep busy drop", 32'(clr_busy), 32'd0);
      check("sweep host_gnt", 32'(host_gnt), 32'd1);
      check("sweep host ad", 32'(ram_ad), 32'h123);
      @(negedge clk);
      host_req = 1'b0;
      #1;
      check("sweep host_rvalid", 32'(host_rvalid), 32'd1);
      check("sweep host_rdata", 32'(host_rdata), 32'h0000);
      check("sweep done pulse", 32'(clr_done), 32'd0);
    end
`else
    #1;
    check("no sweep busy", 32'(clr_busy), 32'd0);
`endif

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      core_req = vec[i].c_req; core_we = vec[i].c_we; core_addr = vec[i].c_ad; core_wdata = vec[i].c_wd;
      host_req = vec[i].h_req; host_we = vec[i].h_we; host_addr = vec[i].h_ad; host_wdata = vec[i].h_wd;
      #1;
      check($sformatf("v%0d core_gnt", i), 32'(core_gnt), 32'(vec[i].e_cg));
      check($sformatf("v%0d host_gnt", i), 32'(host_gnt), 32'(vec[i].e_hg));
      check($sformatf("v%0d ram_ce", i), 32'(ram_ce), 32'(vec[i].e_ce));
      check($sformatf("v%0d ram_we", i), 32'(ram_we), 32'(vec[i].e_we));
      if (vec[i].e_ce) check($sformatf("v%0d ram_ad", i), 32'(ram_ad), 32'(vec[i].e_ad));
      if (vec[i].e_we) check($sformatf("v%0d ram_din", i), 32'(ram_din), 32'(vec[i].e_din));
      check($sformatf("v%0d core_rvalid", i), 32'(core_rvalid), 32'(vec[i].e_crv));
      check($sformatf("v%0d host_rvalid", i), 32'(host_rvalid), 32'(vec[i].e_hrv));
      if (vec[i].e_crv) check($sformatf("v%0d core_rdata", i), 32'(core_rdata), 32'(vec[i].e_rd));
      if (vec[i].e_hrv) check($sformatf("v%0d host_rdata", i), 32'(host_rdata), 32'(vec[i].e_rd));
      check($sformatf("v%0d wait_cnt", i), 32'(dut.wait_cnt_q), 32'(vec[i].e_wait));
    end

    // clr_start in the same cycle as a core read grant
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_addr = 11'h7FF; clr_start = 1'b1;
    #1;
    check("cs core_gnt", 32'(core_gnt), 32'd1);
    @(negedge clk);
    core_req = 1'b0; clr_start = 1'b0;
    #1;
    check("cs core_rvalid", 32'(core_rvalid), 32'd1);
    check("cs core_rdata", 32'(core_rdata), 32'h1234);
`ifdef DSP_RAM_CLEAR_EN
    check("cs busy", 32'(clr_busy), 32'd1);
    check("cs ad0", 32'(ram_ad), 32'h000);
    host_req = 1'b1; host_addr = 11'h010;
    repeat (16'h400) @(negedge clk);
    #1;
    check("mid ad400", 32'(ram_ad), 32'h400);
    resetn = 1'b0;
    #1;
    check("mid rst busy", 32'(clr_busy), 32'd0);
    check("mid rst ram_ce", 32'(ram_ce), 32'd0);
    check("mid rst host_gnt", 32'(host_gnt), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("mid restart ad", 32'(ram_ad), 32'h000);
    check("mid restart busy", 32'(clr_busy), 32'd1);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 2100 && !seen; i++) begin
        @(negedge clk);
        #1;
        seen = clr_done;
      end
      check("mid sweep done", 32'(seen), 32'd1);
      check("mid host_gnt", 32'(host_gnt), 32'd1);
    end
    host_req = 1'b0;
`else
    check("cs busy ignored", 32'(clr_busy), 32'd0);
    check("cs done ignored", 32'(clr_done), 32'd0);
`endif

    // reset while a read return is pending
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_addr = 11'h055;
    @(negedge clk);
    #1;
    check("rr rvalid", 32'(core_rvalid), 32'd1);
    resetn = 1'b0;
    #1;
    check("rr rvalid drop", 32'(core_rvalid), 32'd0);
    check("rr gnt drop", 32'(core_gnt), 32'd0);
    core_req = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dsp_ram_arbiter.md
# dsp_ram_arbiter

Shares the single read/write port A of the DSP coprocessor's 2K×16 data RAM between two requesters: the DSP core's microcode data accesses and the host side (SNES bus bridge / save-state loader). Core accesses have priority, and a wait counter bounds host starvation. An optional sweep engine zero-fills the whole RAM after reset or on command. Sits between the DSP core, the host bridge and the data RAM macro; RAM port B is not touched by this block.

## Interface
Parameters:
- AW, 11, RAM word address width (2048 words)
- DW, 16, data width
- HOST_WAIT_MAX, 4, max consecutive cycles a pending host request loses to core (1..15)

Ports:
- clk  in  1  system clock; RAM port A runs on the same clock
- resetn  in  1  asynchronous, active-low reset
- core_req  in  1  core access request; held with stable addr/we/wdata until core_gnt
- core_we  in  1  1 = write, 0 = read
- core_addr  in  AW  core word address
- core_wdata  in  DW  core write data
- core_gnt  out  1  combinational; request accepted this cycle
- core_rvalid  out  1  core read data valid on core_rdata
- core_rdata  out  DW  read data
- host_req, host_we, host_addr, host_wdata  in  1/1/AW/DW  same rules as core
- host_gnt, host_rvalid  out  1  same rules as core
- host_rdata  out  DW  read data
- clr_start  in  1  pulse; begins zero-fill sweep (only with DSP_RAM_CLEAR_EN)
- clr_busy  out  1  sweep in progress
- clr_done  out  1  one-cycle pulse after last sweep write
- ram_ce, ram_we  out  1  RAM port A enable / write enable
- ram_ad  out  AW  RAM port A address
- ram_din  out  DW  RAM port A write data
- ram_dout  in  DW  RAM port A read data (valid one clk after the sampling edge; output register not used)

## Operation
- States: RUN, CLEAR. Reset enters RUN (or CLEAR when DSP_RAM_CLEAR_EN; see Configuration).
- RUN arbitration, evaluated every cycle:
  - host wins if host_req && (!core_req || wait_cnt == HOST_WAIT_MAX); otherwise core wins if core_req.
  - The winner's gnt = 1; ram_ce = 1; ram_we/ram_ad/ram_din = the winner's signals. With no request, ram_ce = 0 and ram_we = 0.
  - At most one gnt per cycle.
- wait_cnt (4-bit):
  - increments when host_req && !host_gnt, saturating at HOST_WAIT_MAX;
  - clears on host_gnt or when !host_req.
- Read return: a granted read sets the owner's rvalid in the next cycle. rdata is ram_dout passed through (both rdata outputs are driven by ram_dout; qualify with rvalid). Writes produce no rvalid.
- CLEAR:
  - ram_ce = ram_we = 1, ram_din = 0, ram_ad = sweep counter 0..2^AW-1, one word per cycle.
  - No grants are issued; requests stay pending.
  - After address 2^AW-1 is written, clr_done pulses, clr_busy drops, and the state returns to RUN.
- clr_start while clr_busy is ignored. clr_start in RUN takes effect in the next cycle. A grant in the clr_start cycle still completes, and its rvalid still fires in the first CLEAR cycle.
- Reset mid-sweep or mid-read: all state clears; any pending rvalid is dropped.

## Timing
- Grant latency: 0 cycles (combinational from req when the port is free). Read data latency: 1 cycle after gnt.
- Back-to-back: a requester holding req is granted on consecutive cycles if it keeps winning. Throughput is 1 access/clk.
- Worst-case host latency under continuous core traffic: HOST_WAIT_MAX+1 cycles.
- Sweep duration: 2^AW cycles (2048). clr_done is asserted in the cycle after the final write.
- Reset values: core_rvalid = host_rvalid = 0, clr_busy = 0 (1 if the reset sweep is enabled), clr_done = 0, wait_cnt = 0, sweep counter = 0. While resetn is low: gnt outputs = 0 and ram_ce = ram_we = 0.

## Configuration
- DSP_RAM_CLEAR_EN:
  - Defined: the CLEAR state and sweep counter are built. Reset exits into CLEAR, so the RAM is zero-filled after every reset, with clr_busy = 1 out of reset. clr_start can re-trigger the sweep.
  - Undefined: CLEAR logic is removed, clr_start is ignored, and clr_busy = clr_done = 0 constantly.

## Test plan
- Core only: write 0x1234 to 0x7FF, then read 0x7FF -> core_gnt on each request cycle; core_rvalid = 1 exactly one cycle after the read grant with core_rdata = 0x1234.
- Simultaneous: core and host both request reads every cycle (HOST_WAIT_MAX = 4) -> core granted 4 cycles, host granted on the 5th, then the pattern repeats; gnts are never both 1.
- Host alone: host writes 0xBEEF to 0x000, core idle -> host_gnt in the same cycle; wait_cnt stays 0.
- Sweep (macro on): release resetn -> clr_busy high for 2048 cycles with ram_we = 1 and ram_din = 0, addresses 0..0x7FF in order; clr_done pulses once; a host read of 0x123 held during the sweep is granted in the first RUN cycle and returns 0x0000.
- clr_start issued in the same cycle as a core read grant -> that read's rvalid still asserts next cycle; the sweep starts next cycle; a second clr_start at sweep address 0x100 is ignored.
- Assert resetn low mid-sweep at address 0x400 -> clr_busy, rvalid and gnt all drop to 0 asynchronously; after release the sweep restarts at 0x000.
